sipo_deserializer: RTL
======================

Name: sipo_deserializer

Overview:
- Serial-in/parallel-out receiver: the receive end of the team's MSB-first PISO serial link.
- Shifts one bit per enabled clock from SI, counts N bits per word, then presents the assembled word on O with a one-cycle VALID strobe.
- Optional SYNC input realigns word framing; a misaligned SYNC is flagged on SYNC_ERR.
- Sits at the far end of a PISO link, feeding the parallel word to downstream logic.

Parameters:
- N, 8: word width in bits; legal range 2..32.
- CW, $clog2(N): bit-counter width (derived; not overridden).

Ports:
- CLK  input  1  rising-edge clock.
- RESET  input  1  asynchronous, active-high reset.
- CE  input  1  clock enable; a bit is sampled only when CE=1.
- SI  input  1  serial data; first bit of a word is the MSB.
- SYNC  input  1  marks SI as the first bit (MSB) of a word; qualified by CE.
- O  output  N  last completed word; O[N-1] is the first bit received.
- VALID  output  1  one-cycle strobe: O was updated at the preceding edge.
- SYNC_ERR  output  1  one-cycle strobe: SYNC arrived while a word was partially received.

Behaviour:
- Reset (asynchronous, RESET=1): shift register, cnt, O, VALID and SYNC_ERR all 0. Reset mid-word discards the partial word; O returns to 0.
- State: shift register sr[N-2:0] holds received bits, newest at sr[0]; bit counter cnt, range 0..N-1, counts bits already held.
- Edge with CE=1 and SYNC=0:
  - sr <= {sr[N-3:0], SI}.
  - If cnt==N-1: O <= {sr[N-2:0], SI}, VALID <= 1, cnt <= 0.
  - Otherwise: cnt <= cnt+1, VALID <= 0.
- Edge with CE=1 and SYNC=1:
  - sr[0] <= SI; cnt <= 1; VALID <= 0; O unchanged.
  - SYNC_ERR <= (cnt != 0).
  - SYNC wins over word completion: when cnt==N-1, the partial word is dropped, no VALID, and SYNC_ERR=1.
- Edge with CE=0: sr, cnt and O hold; VALID <= 0; SYNC_ERR <= 0. SI and SYNC are ignored.
- SYNC_ERR <= 0 on every edge not described above.
- Latency: MSB sampled at edge k and LSB at edge k+N-1 (CE continuously high) gives VALID=1 and the new O during the cycle after edge k+N-1. VALID never stays high for more than one consecutive cycle.
- Back-to-back words with CE held high: VALID every N cycles, no bubble.
- Gaps: CE gaps anywhere inside a word are tolerated; the word completes on the Nth enabled bit.
- Free-running framing: without SYNC, framing starts from reset (the first enabled bit after reset is an MSB).
- O is registered and holds its value between VALID strobes.
- All outputs come straight from flops; no combinational path from inputs to outputs.

Decomposition:
- Shared package: PISO/SIPO link constants (default word width, bit order = MSB first), shared with the transmit side.
- One natural sub-module: sipo_bit_counter (mod-N counter with enable, synchronous load-to-1, and terminal-count flag).
- Shift/capture datapath stays in the top module.

Test Plan:
- Reset mid-word: N=8, shift 5 bits, pulse RESET asynchronously between edges -> O=0x00, VALID=0 immediately. The next 8 enabled bits 10100101 -> O=0xA5, VALID for exactly 1 cycle.
- Back-to-back words: N=8, CE=1 continuous, stream 0x3C then 0xFF -> VALID high in cycles 8 and 16 after the first bit. O=0x3C, then O=0xFF. VALID low in all other cycles.
- CE gaps: N=2, bits 1,(CE=0 for 3 cycles),0 -> O=2'b10, VALID 1 cycle after the second enabled bit. O, cnt and VALID unchanged during the gap.
- Aligned SYNC: N=8, SYNC with the first bit of 0x81 while cnt==0 -> O=0x81, SYNC_ERR never asserted.
- Misaligned SYNC: N=8, after 3 bits assert SYNC with the first bit of 0x5A -> SYNC_ERR=1 for 1 cycle, no VALID for the partial word, then O=0x5A with VALID.
- SYNC at terminal count: N=8, cnt==7 with SYNC=1 -> no VALID, SYNC_ERR=1, O keeps its previous value, cnt=1.

Source files
------------

// File: rtl/sipo_deserializer_pkg.sv
// Constants shared by both ends of the PISO/SIPO serial link.
package sipo_deserializer_pkg;

    typedef enum logic {
        MSB_FIRST = 1'b0,
        LSB_FIRST = 1'b1
    } bit_order_e;

    localparam int         LINK_WORD_W    = 8;
    localparam bit_order_e LINK_BIT_ORDER = MSB_FIRST;

endpackage

// File: rtl/sipo_bit_counter.sv
// Mod-N bit counter with enable, synchronous load-to-1 and terminal-count flag.
module sipo_bit_counter #(
    parameter int N  = 8,
    parameter int CW = $clog2(N)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    input  logic          load1_i,
    output logic [CW-1:0] cnt_o,
    output logic          tc_o
);

    logic [CW-1:0] cnt_q;

    assign tc_o  = (cnt_q == CW'(N - 1));
    assign cnt_o = cnt_q;

    // Load-to-1 takes priority: the bit sampled alongside SYNC is already held.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load1_i) begin
            cnt_q <= CW'(1);
        end else if (en_i) begin
            cnt_q <= tc_o ? '0 : cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out receiver for the MSB-first PISO link, with SYNC realignment.
module sipo_deserializer
    import sipo_deserializer_pkg::*;
#(
    parameter int N = LINK_WORD_W
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         CE,
    input  logic         SI,
    input  logic         SYNC,
    output logic [N-1:0] O,
    output logic         VALID,
    output logic         SYNC_ERR
);

    localparam int CW = $clog2(N);

    logic [N-2:0]  sr_q, sr_d;
    logic [N-1:0]  shifted;
    logic [N-1:0]  o_q;
    logic          valid_q;
    logic          sync_err_q;
    logic [CW-1:0] cnt;
    logic          tc;

    sipo_bit_counter #(
        .N  (N),
        .CW (CW)
    ) u_cnt (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .en_i    (CE & ~SYNC),
        .load1_i (CE & SYNC),
        .cnt_o   (cnt),
        .tc_o    (tc)
    );

    // Newest bit enters at the LSB, so the first bit of a word ends up as the MSB.
    always_comb begin
        shifted = {sr_q, SI};
        sr_d    = shifted[N-2:0];
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sr_q       <= '0;
            o_q        <= '0;
            valid_q    <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            valid_q    <= 1'b0;
            sync_err_q <= 1'b0;
            if (CE) begin
                sr_q <= sr_d;
                // SYNC beats word completion: a word cut short by SYNC is dropped.
                if (SYNC) begin
                    sync_err_q <= (cnt != '0);
                end else if (tc) begin
                    o_q     <= shifted;
                    valid_q <= 1'b1;
                end
            end
        end
    end

    assign O        = o_q;
    assign VALID    = valid_q;
    assign SYNC_ERR = sync_err_q;

endmodule
